// File: rtl/add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding,
// operation codes and the digit-counter width helper.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/add_digit.sv
// DIGIT-wide ripple-carry adder built from full-adder cells; also exposes the
// carry into the top bit so the caller can form signed overflow.
module add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             c_in,
  output logic [DIGIT-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign c_out = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock,
// WIDTH/DIGIT cycles per operation, with ovf/cout/zero flags and accumulate.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             ovf,
  output logic             cout,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb;
  logic [WIDTH-1:0] part_nxt;
  logic             accept, step, last;

  assign accept = start && (state_q != RUN);
  assign step   = (state_q == RUN);
  assign last   = step && (cnt_q == LAST);
  assign busy   = (state_q == RUN);
  assign done   = (state_q == FIN);

  add_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (opa_q[DIGIT-1:0]),
    .y    (opb_q[DIGIT-1:0]),
    .c_in (carry_q),
    .s    (dsum),
    .c_out(dcout),
    .c_msb(dcmsb)
  );

  // Partial result holds only the digits already produced; the newest digit
  // enters at the top so the finished word lines up after NDIG steps.
  if (DIGIT == WIDTH) begin : g_one
    assign part_nxt = dsum;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] part_q;

    assign part_nxt = {dsum, part_q};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        part_q <= '0;
      end else if (accept) begin
        part_q <= '0;
      end else if (step) begin
        part_q <= part_nxt[WIDTH-1:DIGIT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = FIN;
      FIN:     state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand shifters, carry and counter; result/flags only move on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s       <= '0;
      ovf     <= 1'b0;
      cout    <= 1'b0;
      zero    <= 1'b0;
    end else if (accept) begin
      opa_q   <= acc ? s : a;
      opb_q   <= b ^ {WIDTH{sel}};
      carry_q <= (sel == OP_SUB);
      cnt_q   <= '0;
    end else if (step) begin
      opa_q   <= opa_q >> DIGIT;
      opb_q   <= opb_q >> DIGIT;
      carry_q <= dcout;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        s    <= part_nxt;
        cout <= dcout;
        ovf  <= dcmsb ^ dcout;
        zero <= (part_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: a 16/4 and an 8/8 instance share stimulus and are
// compared every cycle against a cycle-count/arithmetic reference model.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst_n, start, sel, acc;
  logic [15:0] a, b;

  logic        busy16, done16, ovf16, cout16, zero16;
  logic [15:0] s16;
  logic        busy8, done8, ovf8, cout8, zero8;
  logic [7:0]  s8;

  int total = 0;
  int bad   = 0;
  bit fin   = 1'b0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .acc(acc),
    .a(a), .b(b), .busy(busy16), .done(done16), .s(s16),
    .ovf(ovf16), .cout(cout16), .zero(zero16)
  );

  serial_add_sub #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .acc(acc),
    .a(a[7:0]), .b(b[7:0]), .busy(busy8), .done(done8), .s(s8),
    .ovf(ovf8), .cout(cout8), .zero(zero8)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference arithmetic on w-bit operands: returns {ovf, cout, result}.
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic sub, input int w);
    longint unsigned m, xx, yy, full, r;
    logic c, o, sx, sy, sr;
    m    = (64'd1 << w) - 1;
    xx   = {48'd0, x} & m;
    yy   = {48'd0, y} & m;
    full = sub ? (xx + ((~yy) & m) + 1) : (xx + yy);
    r    = full & m;
    c    = ((full >> w) & 1) != 0;
    sx   = ((xx >> (w - 1)) & 1) != 0;
    sy   = (((yy >> (w - 1)) & 1) != 0) ^ sub;
    sr   = ((r >> (w - 1)) & 1) != 0;
    o    = (sx == sy) && (sr != sx);
    return {o, c, r[15:0]};
  endfunction

  // Model: rem = busy cycles left; result committed when the countdown ends.
  int          rem16 = 0, rem8 = 0;
  logic        md16 = 0, md8 = 0;
  logic [15:0] es16 = 0, ps16 = 0;
  logic [15:0] es8 = 0, ps8 = 0;
  logic        eo16 = 0, ec16 = 0, ez16 = 0, po16 = 0, pc16 = 0;
  logic        eo8 = 0, ec8 = 0, ez8 = 0, po8 = 0, pc8 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem16 <= 0; md16 <= 0; es16 <= 0; eo16 <= 0; ec16 <= 0; ez16 <= 0;
      rem8  <= 0; md8  <= 0; es8  <= 0; eo8  <= 0; ec8  <= 0; ez8  <= 0;
    end else begin
      md16 <= 1'b0;
      if (rem16 == 0 && start) begin
        {po16, pc16, ps16} <= ref_op(acc ? es16 : a, b, sel, 16);
        rem16 <= 4;
      end else if (rem16 > 0) begin
        rem16 <= rem16 - 1;
        if (rem16 == 1) begin
          md16 <= 1'b1; es16 <= ps16; eo16 <= po16; ec16 <= pc16; ez16 <= (ps16 == 0);
        end
      end
      md8 <= 1'b0;
      if (rem8 == 0 && start) begin
        {po8, pc8, ps8} <= ref_op(acc ? es8 : {8'd0, a[7:0]}, {8'd0, b[7:0]}, sel, 8);
        rem8 <= 1;
      end else if (rem8 > 0) begin
        rem8 <= rem8 - 1;
        if (rem8 == 1) begin
          md8 <= 1'b1; es8 <= ps8; eo8 <= po8; ec8 <= pc8; ez8 <= (ps8 == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!fin) begin
      chk("busy16", 32'(busy16), 32'(rem16 != 0));
      chk("done16", 32'(done16), 32'(md16));
      chk("s16",    32'(s16),    32'(es16));
      chk("ovf16",  32'(ovf16),  32'(eo16));
      chk("cout16", 32'(cout16), 32'(ec16));
      chk("zero16", 32'(zero16), 32'(ez16));
      chk("busy8",  32'(busy8),  32'(rem8 != 0));
      chk("done8",  32'(done8),  32'(md8));
      chk("s8",     32'(s8),     32'(es8[7:0]));
      chk("ovf8",   32'(ovf8),   32'(eo8));
      chk("cout8",  32'(cout8),  32'(ec8));
      chk("zero8",  32'(zero8),  32'(ez8));
    end
  end

  // Issue one op (caller ensures the DUT is idle or in its done cycle), wait
  // for done with a bound, and check hand-computed literals. Returns in the done cycle.
  task automatic op(input bit w8, input logic s_, input logic ac,
                    input logic [15:0] a_, input logic [15:0] b_,
                    input logic [15:0] xs, input logic xo, input logic xc,
                    input logic xz, input string n);
    int nb;
    bit got;
    start = 1'b1; sel = s_; acc = ac; a = a_; b = b_;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (w8 ? done8 : done16) begin
        got = 1'b1;
        break;
      end
      nb += w8 ? int'(busy8) : int'(busy16);
      @(posedge clk); #1;
    end
    chk({n, ".done"}, 32'(got), 32'd1);
    chk({n, ".busycyc"}, 32'(nb), w8 ? 32'd1 : 32'd4);
    chk({n, ".s"},    w8 ? 32'(s8) : 32'(s16), 32'(xs));
    chk({n, ".ovf"},  w8 ? 32'(ovf8) : 32'(ovf16), 32'(xo));
    chk({n, ".cout"}, w8 ? 32'(cout8) : 32'(cout16), 32'(xc));
    chk({n, ".zero"}, w8 ? 32'(zero8) : 32'(zero16), 32'(xz));
  endtask

  initial begin
    int nd;
    rst_n = 1'b1; start = 1'b0; sel = 1'b0; acc = 1'b0; a = '0; b = '0;
    #1 rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy16), 32'd0);
    chk("rst.done", 32'(done16), 32'd0);
    chk("rst.s",    32'(s16),    32'd0);
    chk("rst.flags", 32'({ovf16, cout16, zero16}), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(0, 0, 0, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0, "add_ovf");
    @(posedge clk); #1;
    op(0, 1, 0, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, 0, "sub_neg");
    @(posedge clk); #1;
    op(0, 1, 0, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, "sub_ovf");
    op(0, 0, 1, 16'hAAAA, 16'h0001, 16'h8000, 1, 0, 0, "acc_b2b");
    @(posedge clk); #1;
    op(0, 1, 0, 16'h1234, 16'h1234, 16'h0000, 0, 1, 1, "sub_zero");
    @(posedge clk); #1;

    // Start pulsed during RUN must be dropped.
    start = 1'b1; sel = 1'b0; acc = 1'b0; a = 16'h0001; b = 16'h0002;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h0100;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      nd += int'(done16);
      @(posedge clk); #1;
    end
    chk("ignore.ndone", 32'(nd), 32'd1);
    chk("ignore.s", 32'(s16), 32'h0003);

    // Abort mid-operation.
    start = 1'b1; a = 16'h0100; b = 16'h0200;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy16), 32'd0);
    chk("abort.s",    32'(s16),    32'd0);
    chk("abort.flags", 32'({ovf16, cout16, zero16}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      nd += int'(done16);
      @(posedge clk); #1;
    end
    chk("abort.ndone", 32'(nd), 32'd0);
    op(0, 0, 0, 16'h0100, 16'h0200, 16'h0300, 0, 0, 0, "after_abort");
    repeat (4) @(posedge clk);
    #1;

    op(1, 0, 0, 16'h007F, 16'h0001, 16'h0080, 1, 0, 0, "w8_add");
    repeat (4) @(posedge clk);
    #1;

    repeat (800) begin
      start = ($urandom_range(0, 2) == 0);
      sel   = 1'($urandom_range(0, 1));
      acc   = ($urandom_range(0, 3) == 0);
      a     = 16'($urandom);
      b     = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    fin = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Parametrised, digit-serial adder/subtractor for two's-complement operands of WIDTH bits. Each clock it processes DIGIT bits through a ripple adder, so an operation takes WIDTH/DIGIT cycles. It reports signed overflow, carry/no-borrow and zero flags. An accumulate mode uses the previous result as operand A. It is the multi-cycle, area-scalable successor to the team's 4-bit combinational add/sub unit, and serves as the arithmetic core for the lab datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT and >= 2.
DIGIT, 4, bits processed per cycle; DIGIT == WIDTH gives a single-cycle operation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new operation; sampled only when busy == 0.
sel  input  1  0 = A + B, 1 = A - B; captured at start.
acc  input  1  1 = use current s as operand A instead of port a; captured at start.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; s and the flags are valid and updated.
s  output  WIDTH  result register.
ovf  output  1  signed overflow of the last operation.
cout  output  1  carry out of the MSB; for subtraction, 1 = no borrow (A >= B unsigned).
zero  output  1  s == 0 for the last operation.

Behaviour:
- NDIG = WIDTH/DIGIT.
- FSM states:
  - IDLE -> RUN on start; busy == 0 in IDLE.
  - RUN -> FIN after NDIG digit steps.
  - FIN -> IDLE, or FIN -> RUN on start.
  - done = 1 only in FIN.
- Reset (asynchronous, any time, including mid-operation): state = IDLE; busy = 0, done = 0, s = 0, ovf = 0, cout = 0, zero = 0; shift registers, counter and carry cleared. No done is produced for an aborted operation.
- Accept:
  - At the edge where start = 1 and the state is IDLE or FIN, capture opA = acc ? s : a, opB = b ^ {WIDTH{sel}}, carry = sel, digit counter = 0.
  - busy rises after that edge.
  - start while in RUN is ignored; there is no queuing.
- Digit step (each RUN edge):
  - Low DIGIT bits of opA and opB, plus carry, go into a DIGIT-bit ripple sum.
  - The sum digit is shifted into the top of the partial-result register.
  - opA and opB shift right by DIGIT.
  - carry <= digit carry-out; counter increments.
- Final step (counter == NDIG-1):
  - s <= complete partial result.
  - cout <= carry out of bit WIDTH-1.
  - ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero <= (full result == 0).
  - state -> FIN.
- Latency: start is sampled at edge 0; done is high in the cycle after edge NDIG. busy is high for exactly NDIG cycles; done follows immediately for exactly 1 cycle.
- s and the flags hold their values from the previous completion until the next final step; they do not change during RUN.
- Back-to-back: start asserted during the done cycle is accepted. With acc = 1 it uses the just-completed s.
- Arithmetic is modulo 2^WIDTH; no saturation.
- DIGIT == WIDTH: NDIG = 1, so busy is high for 1 cycle and done follows.

Decomposition:
- Shared package add_sub_pkg holds:
  - FSM state encoding IDLE/RUN/FIN;
  - op constants OP_ADD = 0, OP_SUB = 1;
  - a counter-width helper function (clog2 of NDIG, minimum 1).
- One sub-module, add_digit: DIGIT-wide ripple adder built from full-adder cells. Inputs x, y, c_in; outputs s, c_out and c_msb (the carry into the top bit), used for the ovf computation on the final digit.

Test Plan:
- Reset: hold rst_n = 0 with start = 1 -> busy = 0, done = 0, s = 0x0000, ovf = cout = zero = 0.
- WIDTH = 16, DIGIT = 4, add 0x7FFF + 0x0001 -> busy high 4 cycles, then done 1 cycle; s = 0x8000, ovf = 1, cout = 0, zero = 0.
- Subtractions:
  - 0x0005 - 0x0007 -> s = 0xFFFE, ovf = 0, cout = 0.
  - 0x8000 - 0x0001 -> s = 0x7FFF, ovf = 1, cout = 1.
  - 0x1234 - 0x1234 -> s = 0, zero = 1, cout = 1.
- Accumulate and back-to-back:
  - After s = 0x7FFF, assert start in the done cycle with acc = 1, sel = 0, b = 0x0001, a = 0xAAAA -> s = 0x8000, ovf = 1 (a ignored).
  - start pulsed while busy -> ignored; exactly one done.
- Reset mid-operation: drop rst_n at the 2nd RUN cycle -> busy, s and flags are 0 immediately; no done. A new start after release completes normally.
- DIGIT = WIDTH = 8: 0x7F + 0x01 -> busy for 1 cycle; s = 0x80, ovf = 1.
